// File: rtl/pwm_led_ctrl.sv
// Multi-channel PWM LED driver with boundary-synchronous duty updates and optional linear fade.
// pwm lags the period counter by one cycle; no flow control, writes are accepted every cycle.
module pwm_led_ctrl #(
  parameter int CH = 4,
  parameter int W  = 4,
  localparam int SW = $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_ch,
  input  logic [W-1:0]  wr_duty,
  input  logic          wr_fade,
  input  logic [SW-1:0] sel,
  output logic [CH-1:0] pwm,
  output logic          led_out,
  output logic          period_start,
  output logic [CH-1:0] fading
);

  localparam logic [W-1:0] LAST = W'((2 ** W) - 2);

  logic [W-1:0]  cnt;
  logic [W-1:0]  cnt_nxt;
  logic          run;
  logic          boundary;
  logic [W-1:0]  shadow [CH];
  logic [W-1:0]  active [CH];
  logic [CH-1:0] mode;
  logic [SW-1:0] sel_q;
  logic [(2**SW)-1:0] pwm_ext;

  // run holds the counter at 0 for the first cycle after reset so that cycle shows period_start
  assign boundary = run && (cnt == LAST);

  always_comb begin
    cnt_nxt = '0;
    if (run && !boundary) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      run          <= 1'b0;
      period_start <= 1'b0;
      sel_q        <= '0;
    end else begin
      run          <= 1'b1;
      cnt          <= cnt_nxt;
      period_start <= (cnt_nxt == '0);
      if (boundary) sel_q <= sel;
    end
  end

  // Active update reads pre-write shadow/mode, so a coincident write lands one period later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      mode <= '0;
      pwm  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (wr_en && (wr_ch == SW'(i))) begin
          shadow[i] <= wr_duty;
          mode[i]   <= wr_fade;
        end
        if (boundary) begin
          if (!mode[i])                    active[i] <= shadow[i];
          else if (active[i] < shadow[i])  active[i] <= active[i] + 1'b1;
          else if (active[i] > shadow[i])  active[i] <= active[i] - 1'b1;
        end
        pwm[i] <= (cnt < active[i]);
      end
    end
  end

  always_comb begin
    fading = '0;
    for (int i = 0; i < CH; i++) fading[i] = mode[i] && (active[i] != shadow[i]);
  end

  // Unused select codes map onto zero padding, keeping led_out low for out-of-range sel_q
  always_comb begin
    pwm_ext         = '0;
    pwm_ext[CH-1:0] = pwm;
  end

  assign led_out = pwm_ext[sel_q];

endmodule
